// File: rtl/periph_bus_ctrl_pkg.sv
// Shared types and default parameters for the peripheral bus controller.
package periph_bus_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_SEL_LSB    = 16;
    localparam int DEF_SEL_BITS   = 2;
    localparam int DEF_TIMEOUT    = 255;

    // Wide enough for the largest allowed TIMEOUT (65535).
    localparam int CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } bus_state_e;

endpackage

// File: rtl/periph_bus_ctrl_timeout.sv
// Wait-cycle counter: clear, enable, and a terminal flag on the last allowed wait cycle.
module bus_timeout_cnt
    import periph_bus_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TIMEOUT - 1);

    logic [CNT_WIDTH-1:0] cnt_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !term_o) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign term_o = (cnt_q == LAST);

endmodule

// File: rtl/periph_bus_ctrl.sv
// Single-master to N-slave bus controller: decodes the slave from the address,
// holds a one-hot request until the slave is ready or a wait timeout expires.
module periph_bus_ctrl
    import periph_bus_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int SEL_LSB    = DEF_SEL_LSB,
    parameter int SEL_BITS   = DEF_SEL_BITS,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  m_req,
    input  logic                                  m_we,
    input  logic [ADDR_WIDTH-1:0]                 m_addr,
    input  logic [DATA_WIDTH-1:0]                 m_wdata,
    output logic [DATA_WIDTH-1:0]                 m_rdata,
    output logic                                  m_done,
    output logic                                  m_err,
    output logic [(2**SEL_BITS)-1:0]              s_req,
    output logic                                  s_we,
    output logic [SEL_LSB-1:0]                    s_addr,
    output logic [DATA_WIDTH-1:0]                 s_wdata,
    input  logic [(2**SEL_BITS)*DATA_WIDTH-1:0]   s_rdata,
    input  logic [(2**SEL_BITS)-1:0]              s_ready
);

    localparam int N_SLAVES = 2**SEL_BITS;

    bus_state_e            state_q;
    logic                  we_q;
    logic [SEL_LSB-1:0]    addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [SEL_BITS-1:0]   idx_q;
    logic [N_SLAVES-1:0]   s_req_q;
    logic [N_SLAVES-1:0]   s_req_d;
    logic [DATA_WIDTH-1:0] m_rdata_q;
    logic                  m_done_q;
    logic                  m_err_q;

    logic [SEL_BITS-1:0]   sel_idx;
    logic                  ready_sel;
    logic [DATA_WIDTH-1:0] rdata_sel;
    logic                  cnt_clr;
    logic                  cnt_en;
    logic                  cnt_term;

    logic [DATA_WIDTH-1:0] rdata_arr [N_SLAVES];

    for (genvar i = 0; i < N_SLAVES; i++) begin : g_rdata
        assign rdata_arr[i] = s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Address bits above the select field take no part in decoding.
    if (ADDR_WIDTH > SEL_LSB + SEL_BITS) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^m_addr[ADDR_WIDTH-1:SEL_LSB+SEL_BITS];
    end

    assign sel_idx   = m_addr[SEL_LSB+SEL_BITS-1:SEL_LSB];
    assign ready_sel = s_ready[idx_q];
    assign rdata_sel = rdata_arr[idx_q];

    // NOTE: assigning a default before the indexed write keeps this purely combinational (no latch).
    always_comb begin
        s_req_d          = '0;
        s_req_d[sel_idx] = 1'b1;
    end

    assign cnt_clr = (state_q != ST_ACCESS);
    assign cnt_en  = (state_q == ST_ACCESS) && !ready_sel;

    bus_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (reset),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .term_o (cnt_term)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            idx_q     <= '0;
            s_req_q   <= '0;
            m_rdata_q <= '0;
            m_done_q  <= 1'b0;
            m_err_q   <= 1'b0;
        end else begin
            m_done_q <= 1'b0;
            m_err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (m_req) begin
                        we_q    <= m_we;
                        addr_q  <= m_addr[SEL_LSB-1:0];
                        wdata_q <= m_wdata;
                        idx_q   <= sel_idx;
                        s_req_q <= s_req_d;
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Ready is tested first so it wins over a simultaneous timeout.
                    if (ready_sel) begin
                        if (!we_q) begin
                            m_rdata_q <= rdata_sel;
                        end
                        s_req_q  <= '0;
                        m_done_q <= 1'b1;
                        state_q  <= ST_DONE;
                    end else if (cnt_term) begin
                        s_req_q  <= '0;
                        m_done_q <= 1'b1;
                        m_err_q  <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    s_req_q <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_rdata = m_rdata_q;
    assign m_done  = m_done_q;
    assign m_err   = m_err_q;
    assign s_req   = s_req_q;
    assign s_we    = we_q;
    assign s_addr  = addr_q;
    assign s_wdata = wdata_q;

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Directed scoreboard bench for periph_bus_ctrl (TIMEOUT=4, four slaves).
module tb_periph_bus_ctrl;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SL = 16;
    localparam int SB = 2;
    localparam int NS = 4;
    localparam int TO = 4;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    logic             clk     = 1'b0;
    logic             reset   = 1'b1;
    logic             m_req   = 1'b0;
    logic             m_we    = 1'b0;
    logic [AW-1:0]    m_addr  = '0;
    logic [DW-1:0]    m_wdata = '0;
    logic [NS*DW-1:0] s_rdata = '0;
    logic [NS-1:0]    s_ready = '0;

    logic [DW-1:0]    m_rdata;
    logic             m_done;
    logic             m_err;
    logic [NS-1:0]    s_req;
    logic             s_we;
    logic [SL-1:0]    s_addr;
    logic [DW-1:0]    s_wdata;

    exp_t exp_q[$];
    int   n_checks      = 0;
    int   n_fail        = 0;
    int   done_count    = 0;
    int   cyc           = 0;
    int   last_done_cyc = 0;
    int   prev_done_cyc = 0;

    periph_bus_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .SEL_LSB    (SL),
        .SEL_BITS   (SB),
        .TIMEOUT    (TO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_done  (m_done),
        .m_err   (m_err),
        .s_req   (s_req),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata),
        .s_ready (s_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic e);
        exp_t t;
        t.rdata = d;
        t.err   = e;
        exp_q.push_back(t);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_req"},   32'(s_req),   32'h0);
        check({tag, "_s_we"},    32'(s_we),    32'h0);
        check({tag, "_s_addr"},  32'(s_addr),  32'h0);
        check({tag, "_s_wdata"}, s_wdata,      32'h0);
        check({tag, "_m_rdata"}, m_rdata,      32'h0);
        check({tag, "_m_done"},  32'(m_done),  32'h0);
        check({tag, "_m_err"},   32'(m_err),   32'h0);
    endtask

    // Monitor: every completion pulse is matched against the oldest expected response.
    always @(negedge clk) begin
        if (reset && m_done) begin
            exp_t e;
            done_count    = done_count + 1;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got pulse at cycle %0d, expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                check("sb_m_rdata", m_rdata,       e.rdata);
                check("sb_m_err",   32'(m_err),    32'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dc0;

        // Reset state
        #2 reset = 1'b0;
        tick();
        tick();
        check_all_zero("rst");
        reset = 1'b1;
        tick();

        // A: read slave 2, immediate ready
        s_rdata[0*DW +: DW] = 32'h0000_0A00;
        s_rdata[1*DW +: DW] = 32'h0000_0B01;
        s_rdata[2*DW +: DW] = 32'hDEAD_BEEF;
        s_rdata[3*DW +: DW] = 32'h0000_0D03;
        s_ready = 4'b0100;
        m_we    = 1'b0;
        m_addr  = 32'h0002_0010;
        m_req   = 1'b1;
        push_exp(32'hDEAD_BEEF, 1'b0);
        tick();
        check("a_s_req",      32'(s_req),  32'h4);
        check("a_s_addr",     32'(s_addr), 32'h0010);
        check("a_s_we",       32'(s_we),   32'h0);
        check("a_done_early", 32'(m_done), 32'h0);
        m_req = 1'b0;
        tick();
        check("a_m_done",     32'(m_done), 32'h1);
        check("a_s_req_drop", 32'(s_req),  32'h0);
        check("a_m_rdata",    m_rdata,     32'hDEAD_BEEF);
        tick();
        check("a_done_pulse", 32'(m_done), 32'h0);
        s_ready = '0;

        // B: write slave 1, ready after 3 wait cycles (lands on the terminal count)
        m_we    = 1'b1;
        m_addr  = 32'h0001_0004;
        m_wdata = 32'h1234_5678;
        m_req   = 1'b1;
        push_exp(32'hDEAD_BEEF, 1'b0);
        tick();
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_addr  = 32'h0003_FFFF;
        m_wdata = 32'hFFFF_0000;
        for (int k = 0; k < 4; k++) begin
            check("b_s_req",   32'(s_req),  32'h2);
            check("b_s_we",    32'(s_we),   32'h1);
            check("b_s_wdata", s_wdata,     32'h1234_5678);
            check("b_s_addr",  32'(s_addr), 32'h0004);
            check("b_busy",    32'(m_done), 32'h0);
            if (k == 3) s_ready = 4'b0010;
            tick();
        end
        check("b_m_done",     32'(m_done), 32'h1);
        check("b_m_err",      32'(m_err),  32'h0);
        check("b_s_req_drop", 32'(s_req),  32'h0);
        s_ready = '0;
        tick();
        check("b_done_pulse", 32'(m_done), 32'h0);

        // C: slave 3 never ready, others ready (ignored), upper address bits set
        s_rdata[3*DW +: DW] = 32'hBAD0_0003;
        s_ready = 4'b0111;
        m_we    = 1'b0;
        m_addr  = 32'hFFF3_0020;
        m_req   = 1'b1;
        push_exp(32'hDEAD_BEEF, 1'b1);
        tick();
        m_req = 1'b0;
        for (int k = 0; k < TO; k++) begin
            check("c_s_req", 32'(s_req),  32'h8);
            check("c_busy",  32'(m_done), 32'h0);
            tick();
        end
        check("c_m_done",     32'(m_done), 32'h1);
        check("c_m_err",      32'(m_err),  32'h1);
        check("c_s_req_drop", 32'(s_req),  32'h0);
        check("c_m_rdata",    m_rdata,     32'hDEAD_BEEF);
        tick();
        check("c_done_pulse", 32'(m_done), 32'h0);
        check("c_err_pulse",  32'(m_err),  32'h0);
        s_ready = '0;

        // D: slave 3 read completes only on its own ready
        s_rdata[0*DW +: DW] = 32'h1111_0000;
        s_rdata[3*DW +: DW] = 32'hCAFE_0003;
        s_ready = 4'b0001;
        m_addr  = 32'h0003_0008;
        m_req   = 1'b1;
        push_exp(32'hCAFE_0003, 1'b0);
        tick();
        m_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("d_s_req", 32'(s_req),  32'h8);
            check("d_busy",  32'(m_done), 32'h0);
            tick();
        end
        s_ready = 4'b1001;
        check("d_s_req_last", 32'(s_req), 32'h8);
        tick();
        check("d_m_done",  32'(m_done), 32'h1);
        check("d_m_rdata", m_rdata,     32'hCAFE_0003);
        tick();
        s_ready = '0;

        // E: reset during ACCESS cycle 2 aborts, then a fresh read works
        dc0    = done_count;
        m_addr = 32'h0002_0000;
        m_req  = 1'b1;
        tick();
        tick();
        check("e_s_req_busy", 32'(s_req), 32'h4);
        m_req = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_all_zero("e_async");
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("e_no_done", 32'(done_count), 32'(dc0));
        s_rdata[2*DW +: DW] = 32'h5555_AAAA;
        s_ready = 4'b0100;
        m_addr  = 32'h0002_0040;
        m_req   = 1'b1;
        push_exp(32'h5555_AAAA, 1'b0);
        tick();
        m_req = 1'b0;
        check("e_s_req",  32'(s_req),  32'h4);
        check("e_s_addr", 32'(s_addr), 32'h0040);
        tick();
        check("e_m_done",  32'(m_done), 32'h1);
        check("e_m_rdata", m_rdata,     32'h5555_AAAA);
        tick();
        s_ready = '0;

        // F: back-to-back reads to slaves 0 and 1 with m_req held high
        dc0 = done_count;
        s_rdata[0*DW +: DW] = 32'hA0A0_0000;
        s_rdata[1*DW +: DW] = 32'hB1B1_1111;
        s_ready = 4'b0011;
        m_addr  = 32'h0000_0100;
        m_req   = 1'b1;
        push_exp(32'hA0A0_0000, 1'b0);
        push_exp(32'hB1B1_1111, 1'b0);
        tick();
        check("f_s_req0", 32'(s_req), 32'h1);
        m_addr = 32'h0001_0200;
        tick();
        check("f_m_done0",  32'(m_done), 32'h1);
        check("f_m_rdata0", m_rdata,     32'hA0A0_0000);
        tick();
        check("f_gap", 32'(m_done), 32'h0);
        tick();
        check("f_s_req1",  32'(s_req),  32'h2);
        check("f_s_addr1", 32'(s_addr), 32'h0200);
        m_req = 1'b0;
        tick();
        check("f_m_done1",  32'(m_done), 32'h1);
        check("f_m_rdata1", m_rdata,     32'hB1B1_1111);
        tick();
        tick();
        check("f_done_count", 32'(done_count), 32'(dc0 + 2));
        check("f_done_spacing", 32'(last_done_cyc - prev_done_cyc), 32'd3);
        s_ready = '0;

        check("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/periph_bus_ctrl.md
PERIPH_BUS_CTRL -- requirements
Module: periph_bus_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of data buses.
REQ-002 Parameter ADDR_WIDTH, default 32: width of master address.
REQ-003 Parameter SEL_LSB, default 16: lowest address bit of slave-select field.
REQ-004 Parameter SEL_BITS, default 2: slave-select field width; N_SLAVES = 2**SEL_BITS.
REQ-005 Parameter TIMEOUT, default 255: maximum cycles waited for s_ready before error; range 1..65535.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous active-low reset.
REQ-008 m_req  input  1  master access request, level, held until m_done.
REQ-009 m_we  input  1  1 = write, 0 = read; sampled with m_req.
REQ-010 m_addr  input  ADDR_WIDTH  byte address; sampled with m_req.
REQ-011 m_wdata  input  DATA_WIDTH  write data; sampled with m_req.
REQ-012 m_rdata  output  DATA_WIDTH  read data of last completed read.
REQ-013 m_done  output  1  one-cycle completion pulse.
REQ-014 m_err  output  1  valid with m_done; 1 = timeout.
REQ-015 s_req  output  N_SLAVES  one-hot per-slave request.
REQ-016 s_we  output  1  shared write strobe qualifier.
REQ-017 s_addr  output  SEL_LSB  local offset m_addr[SEL_LSB-1:0].
REQ-018 s_wdata  output  DATA_WIDTH  shared write data.
REQ-019 s_rdata  input  N_SLAVES*DATA_WIDTH  slave i read data in slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-020 s_ready  input  N_SLAVES  slave i completes access when high while s_req[i] high.

Function
REQ-021 FSM states SHALL be IDLE, ACCESS, DONE.
REQ-022 IDLE: on m_req=1, SHALL register m_we, m_addr, m_wdata, decode index = m_addr[SEL_LSB+SEL_BITS-1:SEL_LSB], clear timeout counter, go ACCESS.
REQ-023 ACCESS: s_req SHALL be one-hot at decoded index; s_we, s_addr, s_wdata driven from registered values, stable for whole ACCESS.
REQ-024 ACCESS: if s_ready[index]=1, SHALL capture s_rdata slice into m_rdata (reads only), go DONE with m_err=0.
REQ-025 ACCESS: ready of non-selected slaves SHALL be ignored.
REQ-026 ACCESS: counter increments each cycle without ready; when counter reaches TIMEOUT, go DONE with m_err=1, m_rdata unchanged.
REQ-027 s_ready and timeout in same cycle: ready wins, m_err=0.
REQ-028 DONE: m_done=1 for exactly one cycle; s_req=0; next state IDLE.
REQ-029 m_req still high in IDLE after DONE SHALL start a new access (back-to-back, minimum 3 cycles per access with zero-wait slave).
REQ-030 Minimum latency: m_req sampled edge N, s_req high cycle N+1, m_done high cycle N+2 if s_ready immediate.
REQ-031 m_rdata SHALL hold until next successful read; writes and errors leave it unchanged.
REQ-032 m_we, m_addr, m_wdata changes after sampling SHALL have no effect on the current access.
REQ-033 Address bits above SEL_LSB+SEL_BITS-1 SHALL be ignored by decode.

Reset
REQ-034 reset=0 SHALL immediately force state IDLE, s_req=0, s_we=0, s_addr=0, s_wdata=0, m_rdata=0, m_done=0, m_err=0, counter=0.
REQ-035 reset asserted mid-ACCESS SHALL abort the access with no m_done pulse; first access after release starts from IDLE.

Structure
REQ-036 Shared package SHALL hold the state enumeration typedef and default parameter constants.
REQ-037 One sub-module, bus_timeout_cnt (clear, enable, terminal flag), SHALL implement the timeout counter.
REQ-038 All outputs SHALL be registered.

Verification
REQ-039 Read slave 2 (m_addr=0x0002_0010), s_ready[2] immediate, slice=0xDEADBEEF -> s_req=4'b0100 one cycle, s_addr=0x0010, m_done at N+2, m_rdata=0xDEADBEEF, m_err=0.
REQ-040 Write slave 1, m_wdata=0x12345678, s_ready after 3 wait cycles -> s_req=4'b0010 held 4 cycles, s_we=1, s_wdata stable, m_done once, m_rdata unchanged.
REQ-041 TIMEOUT=4, slave 3 never ready -> m_done with m_err=1 after 4 ACCESS cycles, s_req drops, m_rdata unchanged.
REQ-042 s_ready[0]=1 during access to slave 3 -> ignored; completes only on s_ready[3].
REQ-043 reset=0 during ACCESS cycle 2 -> all outputs zero asynchronously, no m_done; next request completes normally.
REQ-044 m_req held high for two reads to slaves 0 and 1 -> two m_done pulses 3 cycles apart, correct m_rdata each.
